// File: rtl/branch_history_table.sv
// branch_history_table: direct-mapped table of per-branch local histories.
// Each entry holds valid, tag and a HIST_W-bit shift register of outcomes.
// The lookup port (IF_ID_PC) gives the PHT read index combinationally. The
// update port (ID_EX_PC) gives the pre-update history as the PHT write index,
// and on a clock edge it shifts in the resolved outcome or allocates the entry.
// Optional build macro BHT_STATS_EN adds saturating lookup/hit/alloc counters.
module branch_history_table #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8,
    parameter int HIST_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IF_ID_PC,
    input  logic              IF_ID_valid,
    input  logic [31:0]       ID_EX_PC,
    input  logic              ID_EX_Branch,
    input  logic              PCSrc,
    input  logic              flush,
    output logic              PHTrd,
    output logic [HIST_W-1:0] PHT_index,
    output logic [HIST_W-1:0] PHT_Windex
`ifdef BHT_STATS_EN
    ,
    output logic [15:0]       lookup_cnt,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       alloc_cnt
`endif
);

    // Table storage, one flop per bit so that reset clears every entry at once.
    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [HIST_W-1:0] hist_q  [ENTRIES];

    // Address decode for both ports.
    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic              rd_hit;
    logic              wr_hit;
    logic              upd_en;
    logic [HIST_W-1:0] wr_hist_next;

    assign rd_idx = IF_ID_PC[IDX_W+1:2];
    assign rd_tag = IF_ID_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign wr_idx = ID_EX_PC[IDX_W+1:2];
    assign wr_tag = ID_EX_PC[IDX_W+TAG_W+1:IDX_W+2];

    // Word-offset and high PC bits never select or tag an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_ID_PC[31:IDX_W+TAG_W+2], IF_ID_PC[1:0],
                              ID_EX_PC[31:IDX_W+TAG_W+2], ID_EX_PC[1:0]};

    // Hit detection is gated by reset so outputs are forced low while it is held.
    assign rd_hit = reset && IF_ID_valid && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign wr_hit = reset && valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign upd_en = ID_EX_Branch && !flush;

    // Both indices read the registered history, so a same-cycle write is not bypassed.
    assign PHTrd      = rd_hit;
    assign PHT_index  = rd_hit ? hist_q[rd_idx] : '0;
    assign PHT_Windex = wr_hit ? hist_q[wr_idx] : '0;

    // Shift in the outcome on a tag hit; otherwise start a fresh history.
    assign wr_hist_next = wr_hit ? {hist_q[wr_idx][HIST_W-2:0], PCSrc}
                                 : {{(HIST_W-1){1'b0}}, PCSrc};

    // Table update: allocate or shift the ID_EX_PC entry on an unflushed branch.
    // NOTE: the table is small and must read as empty right after reset, so every
    // entry is a resettable flop rather than an unreset RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                hist_q[i]  <= '0;
            end
        end else if (upd_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            hist_q[wr_idx]  <= wr_hist_next;
        end
    end

`ifdef BHT_STATS_EN
    // Saturating event counters; each one reflects its event one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lookup_cnt <= '0;
            hit_cnt    <= '0;
            alloc_cnt  <= '0;
        end else begin
            if (IF_ID_valid && lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 16'd1;
            if (rd_hit && hit_cnt != 16'hFFFF)         hit_cnt    <= hit_cnt + 16'd1;
            if (upd_en && !wr_hit && alloc_cnt != 16'hFFFF)
                alloc_cnt <= alloc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table: directed and random stimulus against a table model
// held in plain arrays. The driver pushes expected outputs into a queue; a
// separate monitor samples the DUT and pops/compares every cycle.
module tb_branch_history_table;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 8;
    localparam int HIST_W  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] ex_pc;
    logic        ex_branch;
    logic        pc_src;
    logic        flush;
    logic        PHTrd;
    logic [HIST_W-1:0] PHT_index;
    logic [HIST_W-1:0] PHT_Windex;
`ifdef BHT_STATS_EN
    logic [15:0] lookup_cnt;
    logic [15:0] hit_cnt;
    logic [15:0] alloc_cnt;
`endif

    always #5 clk = ~clk;

    branch_history_table #(
        .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .HIST_W(HIST_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .IF_ID_PC     (if_pc),
        .IF_ID_valid  (if_valid),
        .ID_EX_PC     (ex_pc),
        .ID_EX_Branch (ex_branch),
        .PCSrc        (pc_src),
        .flush        (flush),
        .PHTrd        (PHTrd),
        .PHT_index    (PHT_index),
        .PHT_Windex   (PHT_Windex)
`ifdef BHT_STATS_EN
        ,
        .lookup_cnt   (lookup_cnt),
        .hit_cnt      (hit_cnt),
        .alloc_cnt    (alloc_cnt)
`endif
    );

    typedef struct {
        string name;
        int    rd;
        int    idx;
        int    widx;
        int    lk;
        int    hc;
        int    ac;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: table contents as plain integers.
    bit m_valid [ENTRIES];
    int m_tag   [ENTRIES];
    int m_hist  [ENTRIES];
    int m_lk, m_hc, m_ac;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_hist[i]  = 0;
        end
        m_lk = 0;
        m_hc = 0;
        m_ac = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at negedge, predict, then advance the model
    // by what the following rising edge will do.
    task automatic step(input string name, input bit rst, input logic [31:0] ipc,
                        input bit iv, input logic [31:0] epc, input bit br,
                        input bit src, input bit fl);
        exp_t e;
        bit   hit;
        @(negedge clk);
        reset     = rst;
        if_pc     = ipc;
        if_valid  = iv;
        ex_pc     = epc;
        ex_branch = br;
        pc_src    = src;
        flush     = fl;
        if (!rst) model_clear();
        #1;
        hit    = rst && iv && model_hit(ipc);
        e.name = name;
        e.rd   = hit ? 1 : 0;
        e.idx  = hit ? m_hist[idx_of(ipc)] : 0;
        e.widx = (rst && model_hit(epc)) ? m_hist[idx_of(epc)] : 0;
        e.lk   = m_lk;
        e.hc   = m_hc;
        e.ac   = m_ac;
        sb_q.push_back(e);
        if (rst) begin
            if (iv)  m_lk = (m_lk < 65535) ? m_lk + 1 : m_lk;
            if (hit) m_hc = (m_hc < 65535) ? m_hc + 1 : m_hc;
            if (br && !fl) begin
                int i;
                i = idx_of(epc);
                if (model_hit(epc)) begin
                    m_hist[i] = (m_hist[i] * 2 + int'(src)) % (1 << HIST_W);
                end else begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(epc);
                    m_hist[i]  = int'(src);
                    m_ac = (m_ac < 65535) ? m_ac + 1 : m_ac;
                end
            end
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".PHTrd"},      {31'd0, PHTrd},             e.rd);
                check({e.name, ".PHT_index"},  {28'd0, PHT_index},         e.idx);
                check({e.name, ".PHT_Windex"}, {28'd0, PHT_Windex},        e.widx);
`ifdef BHT_STATS_EN
                check({e.name, ".lookup_cnt"}, {16'd0, lookup_cnt}, e.lk);
                check({e.name, ".hit_cnt"},    {16'd0, hit_cnt},    e.hc);
                check({e.name, ".alloc_cnt"},  {16'd0, alloc_cnt},  e.ac);
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Directed history expectations, written out independently of the model.
    logic [3:0] seq_hist [4];

    initial begin
        logic [31:0] a, b;
        model_clear();
        reset = 1'b0; if_pc = '0; if_valid = 1'b0; ex_pc = '0;
        ex_branch = 1'b0; pc_src = 1'b0; flush = 1'b0;
        seq_hist[0] = 4'b0001; seq_hist[1] = 4'b0010;
        seq_hist[2] = 4'b0101; seq_hist[3] = 4'b1011;

        // Held in reset with busy inputs: everything reads zero.
        step("rst_hold",  0, 32'h40, 1, 32'h40, 1, 1, 0);
        step("rst_hold2", 0, 32'h40, 1, 32'h40, 1, 1, 0);

        // Cold lookup after release.
        step("cold_lookup", 1, 32'h40, 1, 32'h0, 0, 0, 0);

        // Train 0x40 with 1,0,1,1; lookup of the same entry shows the old value.
        step("train0", 1, 32'h40, 1, 32'h40, 1, 1, 0);
        step("train1", 1, 32'h40, 1, 32'h40, 1, 0, 0);
        step("train2", 1, 32'h40, 1, 32'h40, 1, 1, 0);
        step("train3", 1, 32'h40, 1, 32'h40, 1, 1, 0);
        step("trained_lookup", 1, 32'h40, 1, 32'h0, 0, 0, 0);
        @(negedge clk);
        #2;
        check("trained_hist_literal", {28'd0, PHT_index}, {28'd0, seq_hist[3]});

        // Aliasing PC: same index, different tag, replaces the entry.
        step("alias_upd",     1, 32'h40,   1, 32'h1040, 1, 0, 0);
        step("alias_old_pc",  1, 32'h40,   1, 32'h0,    0, 0, 0);
        step("alias_new_pc",  1, 32'h1040, 1, 32'h1040, 0, 0, 0);

        // Build 0011 at 0x80, then read and write it in the same cycle.
        step("e80_a", 1, 32'h0, 0, 32'h80, 1, 0, 0);
        step("e80_b", 1, 32'h0, 0, 32'h80, 1, 1, 0);
        step("e80_c", 1, 32'h0, 0, 32'h80, 1, 1, 0);
        step("e80_rw",   1, 32'h80, 1, 32'h80, 1, 1, 0);
        step("e80_next", 1, 32'h80, 1, 32'h80, 0, 0, 0);

        // Flushed branch leaves the table and alloc counter alone.
        step("flush_upd",   1, 32'h80, 1, 32'h80,  1, 0, 1);
        step("flush_alloc", 1, 32'h80, 1, 32'h3C4, 1, 1, 1);
        step("flush_after", 1, 32'h80, 1, 32'h3C4, 0, 0, 0);

        // Update edge, then reset straight away with a branch still pending.
        step("pre_rst_upd", 1, 32'h80, 1, 32'h80, 1, 1, 0);
        step("mid_rst",     0, 32'h80, 1, 32'h80, 1, 1, 0);
        step("post_rst",    1, 32'h80, 1, 32'h0,  0, 0, 0);
        step("first_upd",   1, 32'h80, 1, 32'h80, 1, 1, 0);
        step("first_upd_v", 1, 32'h80, 1, 32'h80, 0, 0, 0);

        // Random traffic over a few tags so hits, aliases and flushes mix.
        for (int n = 0; n < 600; n++) begin
            a = ($urandom_range(0, 3) << 14) | ($urandom_range(1, 3) << 6)
              | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            b = ($urandom_range(0, 3) << 14) | ($urandom_range(1, 3) << 6)
              | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) b = a;
            step("rand", ($urandom_range(0, 99) != 0), a, ($urandom_range(0, 4) != 0),
                 b, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
